axi_txn_scheduler: RTL and testbench
====================================

# axi_txn_scheduler

Shares the single M00_AXI master port of IP_Core among NUM_REQ on-chip requesters, one transaction at a time.
- Arbitrates pending requests round-robin and latches the winner's address, data and direction onto the master's command inputs.
- Fires the master's one-cycle INIT pulse, then waits for the master's done edge.
- Returns a per-requester completion pulse with error/timeout status and read data.
- A timed-out transaction latches a sticky fault that halts further granting until software clears it.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- TIMEOUT_CYCLES, 1024: maximum cycles in WAIT before declaring timeout (≥4).

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETN  in  1  reset, asynchronous assert, active-low.
- req  in  NUM_REQ  per-requester request level; held until own ack.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses, requester i at bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  flattened write data.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- ack  out  NUM_REQ  one-cycle completion pulse to the served requester.
- rsp_error  out  1  valid with any ack bit; master error or timeout.
- rsp_timeout  out  1  valid with any ack bit; timeout occurred.
- rsp_rdata  out  DATA_W  valid with ack when the transaction was a read.
- grant_id  out  clog2(NUM_REQ)  requester currently owning the master.
- busy  out  1  high in every state other than IDLE.
- fault  out  1  sticky timeout flag; granting halted while high.
- clear_fault  in  1  one-cycle pulse; clears fault and returns to IDLE.
- M00_AXI_INIT_AXI_TXN  out  1  start pulse to the master.
- M00_AXI_TXN_DONE  in  1  master done level.
- M00_AXI_ERROR  in  1  master error level.
- m_addr  out  ADDR_W  command address to the master.
- m_wdata  out  DATA_W  command write data to the master.
- m_we  out  1  command direction to the master.
- m_rdata  in  DATA_W  read data from the master.

## Operation
- States: IDLE, ISSUE, WAIT, RESP, HALT.
- **IDLE**
  - eligible = req & ~mask.
  - If eligible ≠ 0: grant the first set bit searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - Register grant_id, m_addr, m_wdata and m_we from the winner; go to ISSUE.
- **ISSUE** (one cycle): M00_AXI_INIT_AXI_TXN = 1; clear the timeout counter; go to WAIT.
- **WAIT**
  - done_q is M00_AXI_TXN_DONE registered.
  - Completion is the rising edge (DONE & ~done_q). On completion: capture ERROR and m_rdata, go to RESP.
  - Level-high DONE left over from a previous transaction is not a completion.
  - The counter increments each WAIT cycle. If it reaches TIMEOUT_CYCLES−1 without completion: rsp_error = 1, rsp_timeout = 1, set fault, go to RESP.
- **RESP** (one cycle)
  - ack[grant_id] = 1; rsp_* valid; last_grant ← grant_id.
  - mask ← one-hot(grant_id) for exactly the next IDLE cycle, so the requester can drop req.
  - Next state: HALT if fault is set, else IDLE.
- **HALT**: no grants. clear_fault clears fault and goes to IDLE; clear_fault in any other state is ignored.
- m_addr, m_wdata and m_we stay stable from ISSUE through RESP.
- A requester dropping req after grant does not abort the transaction; ack is still pulsed.
- Done or error edges arriving outside WAIT are ignored.

## Timing
- Reset values:
  - State IDLE, last_grant = NUM_REQ−1 (requester 0 wins first).
  - Outputs: ack = 0, INIT = 0, busy = 0, fault = 0, grant_id = 0, rsp_* = 0, m_* = 0, mask = 0, done_q = 0.
- Reset assertion mid-transaction forces reset values immediately. The master is not notified.
- Request-to-INIT latency: req high at edge 0 in IDLE → INIT high in cycle 1.
- Done-to-ack latency: DONE rising sampled at edge k → ack high in cycle k+1.
- Minimum spacing of INIT pulses is 4 cycles.
- INIT is high exactly one cycle per transaction.
- Outputs are registered; ack and rsp_* change only on ACLK edges.
- The counter is clog2(TIMEOUT_CYCLES) wide and never wraps.

## Test plan
- **Single request:** req = 4'b0001, addr 0x40, we = 1; DONE rises 10 cycles after INIT, ERROR = 0 → one INIT pulse, m_addr = 0x40, ack = 4'b0001 one cycle after the DONE edge, rsp_error = 0.
- **Round-robin:** req = 4'b1111 held, with each requester dropping its req after its ack → grants in order 0,1,2,3. Then requester 0 re-requests while 2 also requests → grant 0 (searching from 3+1 wraps to 0), then 2.
- **Error and read:** read with ERROR = 1 and m_rdata = 0xDEADBEEF at the DONE edge → ack carries rsp_error = 1, rsp_timeout = 0, rsp_rdata = 0xDEADBEEF.
- **Timeout and fault:** TIMEOUT_CYCLES = 16, DONE never rises → ack after 16 WAIT cycles with rsp_error = rsp_timeout = 1. fault = 1 and pending req gets no grant for 50 cycles. clear_fault → grant on the next IDLE cycle.
- **Stale done:** DONE held high from a prior transaction → no completion until DONE falls then rises; ack follows the new rising edge only.
- **Reset mid-WAIT:** ARESETN low during WAIT → busy = 0, INIT = 0, ack = 0 immediately. After release, req = 4'b0110 → requester 1 is granted first.

Source files
------------

// File: rtl/axi_txn_scheduler.sv
// Round-robin scheduler sharing one M00_AXI master among NUM_REQ requesters,
// one transaction at a time, with completion timeout and a sticky fault halt.
module axi_txn_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
  input  logic [NUM_REQ-1:0]           req_we,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         rsp_error,
  output logic                         rsp_timeout,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic                         fault,
  input  logic                         clear_fault,
  output logic                         M00_AXI_INIT_AXI_TXN,
  input  logic                         M00_AXI_TXN_DONE,
  input  logic                         M00_AXI_ERROR,
  output logic [ADDR_W-1:0]            m_addr,
  output logic [DATA_W-1:0]            m_wdata,
  output logic                         m_we,
  input  logic [DATA_W-1:0]            m_rdata
);
  localparam int GID_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, HALT} state_t;

  state_t              r_state;
  logic [GID_W-1:0]    r_gid, r_last;
  logic [NUM_REQ-1:0]  r_mask, r_ack;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_done_q, r_init, r_busy, r_fault, r_err, r_to, r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata, r_rdata;

  logic [NUM_REQ-1:0][ADDR_W-1:0] w_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] w_wdata;
  logic [NUM_REQ-1:0]  w_elig, w_gnt_oh;
  logic [GID_W-1:0]    w_win;
  logic                w_found, w_done_edge;
  int                  w_idx;

  assign w_addr      = req_addr;
  assign w_wdata     = req_wdata;
  assign w_elig      = req & ~r_mask;
  assign w_done_edge = M00_AXI_TXN_DONE & ~r_done_q;
  assign w_gnt_oh    = NUM_REQ'(1) << r_gid;

  // First eligible requester after the previous winner, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = (int'(r_last) + i) % NUM_REQ;
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = GID_W'(w_idx);
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state  <= IDLE;
      r_gid    <= '0;
      r_last   <= GID_W'(NUM_REQ - 1);
      r_mask   <= '0;
      r_ack    <= '0;
      r_cnt    <= '0;
      r_done_q <= 1'b0;
      r_init   <= 1'b0;
      r_busy   <= 1'b0;
      r_fault  <= 1'b0;
      r_err    <= 1'b0;
      r_to     <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      r_done_q <= M00_AXI_TXN_DONE;
      r_init   <= 1'b0;
      r_ack    <= '0;
      case (r_state)
        IDLE: begin
          r_mask <= '0;
          if (w_found) begin
            r_gid   <= w_win;
            r_addr  <= w_addr[w_win];
            r_wdata <= w_wdata[w_win];
            r_we    <= req_we[w_win];
            r_init  <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (w_done_edge) begin
            r_err   <= M00_AXI_ERROR;
            r_to    <= 1'b0;
            r_rdata <= m_rdata;
            r_ack   <= w_gnt_oh;
            r_state <= RESP;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_err   <= 1'b1;
            r_to    <= 1'b1;
            r_rdata <= '0;
            r_fault <= 1'b1;
            r_ack   <= w_gnt_oh;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          // Mask survives HALT so it is consumed by the first IDLE cycle.
          r_last  <= r_gid;
          r_mask  <= w_gnt_oh;
          r_err   <= 1'b0;
          r_to    <= 1'b0;
          r_rdata <= '0;
          if (r_fault) begin
            r_state <= HALT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        HALT: begin
          if (clear_fault) begin
            r_fault <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ack                  = r_ack;
  assign rsp_error            = r_err;
  assign rsp_timeout          = r_to;
  assign rsp_rdata            = r_rdata;
  assign grant_id             = r_gid;
  assign busy                 = r_busy;
  assign fault                = r_fault;
  assign M00_AXI_INIT_AXI_TXN = r_init;
  assign m_addr               = r_addr;
  assign m_wdata              = r_wdata;
  assign m_we                 = r_we;
endmodule

// File: tb/tb_axi_txn_scheduler.sv
// Directed bench for axi_txn_scheduler: expected grants and responses are
// queued when stimulus is driven and compared when INIT / ack appear.
module tb_axi_txn_scheduler;
  localparam int NR = 4, AW = 32, DW = 32, TO = 16;

  logic            ACLK = 1'b0, ARESETN = 1'b0;
  logic [NR-1:0]   req = '0, req_we = '0, ack;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic            rsp_error, rsp_timeout, busy, fault, clear_fault = 1'b0;
  logic [DW-1:0]   rsp_rdata, m_wdata, m_rdata = '0;
  logic [AW-1:0]   m_addr;
  logic [1:0]      grant_id;
  logic            INIT, DONE = 1'b0, ERR = 1'b0, m_we;

  axi_txn_scheduler #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_we(req_we), .ack(ack), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .rsp_rdata(rsp_rdata), .grant_id(grant_id), .busy(busy), .fault(fault),
    .clear_fault(clear_fault), .M00_AXI_INIT_AXI_TXN(INIT), .M00_AXI_TXN_DONE(DONE),
    .M00_AXI_ERROR(ERR), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_rdata(m_rdata));

  always #5 ACLK = ~ACLK;

  typedef struct { logic [1:0] id; logic [31:0] addr; logic we; logic [31:0] wdata; } gnt_t;
  typedef struct { logic [3:0] ack; logic err; logic to; logic chk_rd; logic [31:0] rd; } rsp_t;
  gnt_t gq[$];
  rsp_t sq[$];
  gnt_t mg;
  rsp_t mr;
  int   n_pass = 0, n_total = 0, n_init = 0, n_ack = 0;
  logic prev_init = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor: every INIT pulse and every ack is matched against the queues.
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (INIT) begin
        n_init++;
        chk("init_one_cycle", {63'd0, prev_init}, 64'd0);
        if (gq.size() == 0) chk("init_unexpected", {63'd0, INIT}, 64'd0);
        else begin
          mg = gq.pop_front();
          chk("grant_id", {62'd0, grant_id}, {62'd0, mg.id});
          chk("m_addr", {32'd0, m_addr}, {32'd0, mg.addr});
          chk("m_we", {63'd0, m_we}, {63'd0, mg.we});
          if (mg.we) chk("m_wdata", {32'd0, m_wdata}, {32'd0, mg.wdata});
        end
      end
      if (ack != '0) begin
        n_ack++;
        if (sq.size() == 0) chk("ack_unexpected", {60'd0, ack}, 64'd0);
        else begin
          mr = sq.pop_front();
          chk("ack", {60'd0, ack}, {60'd0, mr.ack});
          chk("rsp_error", {63'd0, rsp_error}, {63'd0, mr.err});
          chk("rsp_timeout", {63'd0, rsp_timeout}, {63'd0, mr.to});
          if (mr.chk_rd) chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, mr.rd});
        end
      end
      prev_init = INIT;
    end else prev_init = 1'b0;
  end

  task automatic do_reset();
    ARESETN = 1'b0; req = '0; DONE = 1'b0; ERR = 1'b0;
    gq.delete(); sq.delete();
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic w, input logic [31:0] d);
    req[i] = 1'b1; req_we[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic exp_gnt(input int i, input logic [31:0] a, input logic w, input logic [31:0] d);
    gq.push_back('{2'(i), a, w, d});
  endtask

  task automatic wait_init(output int n);
    n = 0;
    do begin @(negedge ACLK); n++; end while (!INIT && n < 100);
    if (!INIT) chk("init_wait_expired", {63'd0, INIT}, 64'd1);
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin @(negedge ACLK); n++; end while (ack == '0 && n < 100);
    if (ack == '0) chk("ack_wait_expired", {60'd0, ack}, 64'd1);
  endtask

  // Raise DONE after dly cycles, expect ack one cycle later, then release.
  task automatic complete(input int id, input int dly, input logic err, input logic [31:0] rd,
                          input logic chk_rd, input logic keep_done);
    int n;
    repeat (dly) @(negedge ACLK);
    DONE = 1'b1; ERR = err; m_rdata = rd;
    sq.push_back('{4'(1 << id), err, 1'b0, chk_rd, rd});
    wait_ack(n);
    chk("done_to_ack", 64'(n), 64'd1);
    req[id] = 1'b0; ERR = 1'b0;
    if (!keep_done) DONE = 1'b0;
  endtask

  task automatic serve(input int id, input int dly, input logic err, input logic [31:0] rd,
                       input logic chk_rd);
    int n;
    wait_init(n);
    complete(id, dly, err, rd, chk_rd, 1'b0);
  endtask

  initial begin
    int n, k, i0;
    // Reset values
    repeat (2) @(negedge ACLK);
    chk("rst_ack", {60'd0, ack}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_fault", {63'd0, fault}, 64'd0);
    chk("rst_init", {63'd0, INIT}, 64'd0);
    chk("rst_grant", {62'd0, grant_id}, 64'd0);
    chk("rst_maddr", {32'd0, m_addr}, 64'd0);
    chk("rst_rsp_err", {63'd0, rsp_error}, 64'd0);
    ARESETN = 1'b1;
    @(negedge ACLK);

    // Single write request
    exp_gnt(0, 32'h40, 1'b1, 32'h1234_5678);
    set_req(0, 32'h40, 1'b1, 32'h1234_5678);
    wait_init(n);
    chk("req_to_init", 64'(n), 64'd1);
    chk("busy_in_issue", {63'd0, busy}, 64'd1);
    repeat (9) @(negedge ACLK);
    chk("maddr_stable", {32'd0, m_addr}, 64'h40);
    complete(0, 1, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge ACLK);
    @(negedge ACLK);
    chk("idle_busy", {63'd0, busy}, 64'd0);

    // Round-robin from reset: all four pending
    do_reset();
    for (int i = 0; i < NR; i++) begin
      exp_gnt(i, 32'h100 + i, 1'b0, 32'h0);
      set_req(i, 32'h100 + i, 1'b0, 32'h0);
    end
    for (int i = 0; i < NR; i++) serve(i, 1 + i, 1'b0, 32'hA000 + i, 1'b1);
    exp_gnt(0, 32'h500, 1'b1, 32'h55);
    exp_gnt(2, 32'h520, 1'b1, 32'h77);
    set_req(0, 32'h500, 1'b1, 32'h55);
    set_req(2, 32'h520, 1'b1, 32'h77);
    serve(0, 2, 1'b0, 32'h0, 1'b0);
    serve(2, 3, 1'b0, 32'h0, 1'b0);

    // Read returning an error
    exp_gnt(1, 32'h200, 1'b0, 32'h0);
    set_req(1, 32'h200, 1'b0, 32'h0);
    serve(1, 4, 1'b1, 32'hDEAD_BEEF, 1'b1);

    // Stale DONE: requester 3 leaves DONE high, requester 0 must see a fresh edge
    exp_gnt(3, 32'h300, 1'b0, 32'h0);
    set_req(3, 32'h300, 1'b0, 32'h0);
    wait_init(n);
    complete(3, 2, 1'b0, 32'h3333, 1'b1, 1'b1);
    exp_gnt(0, 32'h600, 1'b0, 32'h0);
    set_req(0, 32'h600, 1'b0, 32'h0);
    wait_init(n);
    k = n_ack;
    repeat (6) @(negedge ACLK);
    chk("stale_no_ack", 64'(n_ack - k), 64'd0);
    chk("stale_busy", {63'd0, busy}, 64'd1);
    DONE = 1'b0;
    complete(0, 1, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0);

    // Timeout: DONE never rises, fault halts granting until cleared
    exp_gnt(2, 32'h700, 1'b0, 32'h0);
    set_req(2, 32'h700, 1'b0, 32'h0);
    wait_init(n);
    sq.push_back('{4'b0100, 1'b1, 1'b1, 1'b0, 32'h0});
    wait_ack(n);
    chk("timeout_latency", 64'(n), 64'(TO + 1));
    chk("fault_set", {63'd0, fault}, 64'd1);
    req[2] = 1'b0;
    set_req(1, 32'h710, 1'b1, 32'h99);
    i0 = n_init;
    repeat (50) @(negedge ACLK);
    chk("halt_no_grant", 64'(n_init - i0), 64'd0);
    chk("halt_fault", {63'd0, fault}, 64'd1);
    chk("halt_busy", {63'd0, busy}, 64'd1);
    exp_gnt(1, 32'h710, 1'b1, 32'h99);
    clear_fault = 1'b1;
    @(negedge ACLK);
    clear_fault = 1'b0;
    chk("fault_cleared", {63'd0, fault}, 64'd0);
    wait_init(n);
    chk("clear_to_init", 64'(n), 64'd1);
    complete(1, 2, 1'b0, 32'h0, 1'b0, 1'b0);

    // Reset mid-WAIT, then 0110 grants requester 1 first
    exp_gnt(3, 32'h800, 1'b0, 32'h0);
    set_req(3, 32'h800, 1'b0, 32'h0);
    wait_init(n);
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b0;
    #1;
    chk("rstw_busy", {63'd0, busy}, 64'd0);
    chk("rstw_init", {63'd0, INIT}, 64'd0);
    chk("rstw_ack", {60'd0, ack}, 64'd0);
    do_reset();
    exp_gnt(1, 32'h910, 1'b0, 32'h0);
    exp_gnt(2, 32'h920, 1'b0, 32'h0);
    set_req(1, 32'h910, 1'b0, 32'h0);
    set_req(2, 32'h920, 1'b0, 32'h0);
    serve(1, 1, 1'b0, 32'h1111, 1'b1);
    serve(2, 2, 1'b0, 32'h2222, 1'b1);

    repeat (3) @(negedge ACLK);
    chk("grants_drained", 64'(gq.size()), 64'd0);
    chk("rsps_drained", 64'(sq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
